// File: rtl/emergency_request_conditioner.sv
// rtl/emergency_request_conditioner.sv - sync, debounce, latch and arbitrate emergency requests
// Channel index 0 is NS, index 1 is EW throughout.
module emergency_request_conditioner #(
  parameter int SYNC_STAGES       = 2,
  parameter int CNT_WIDTH         = 32,
  parameter int DEBOUNCE_TICKS    = 500000,
  parameter int REQ_TIMEOUT_TICKS = 200000000,
  parameter int COOLDOWN_TICKS    = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_emg_ns,
  input  logic       raw_emg_ew,
  input  logic [2:0] state_debug,
  output logic       emg_ns,
  output logic       emg_ew,
  output logic       pending_ns,
  output logic       pending_ew,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_NS, S_REQ_EW, S_WAIT_NS, S_WAIT_EW, S_COOLDOWN
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(REQ_TIMEOUT_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] CD_LAST  = CNT_WIDTH'(COOLDOWN_TICKS - 1);
  localparam logic [2:0] CODE_NS = 3'd6;
  localparam logic [2:0] CODE_EW = 3'd7;

  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [CNT_WIDTH-1:0]   deb_cnt [2];
  logic [1:0]             raw, sync, deb, deb_upd, deb_rise, pend, clr;
  logic [CNT_WIDTH-1:0]   tmo_cnt, cd_cnt;
  logic                   last_ew, tmo_evt;
  logic                   emg_ns_d, emg_ew_d, busy_d;
  state_t                 state, state_next;

  assign raw        = {raw_emg_ew, raw_emg_ns};
  assign pending_ns = pend[0];
  assign pending_ew = pend[1];

  // The deb update edge doubles as the pending set, so pending rises with deb.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync[i]     = sync_q[i][SYNC_STAGES-1];
      deb_upd[i]  = (sync[i] != deb[i]) && (deb_cnt[i] >= DEB_LAST);
      deb_rise[i] = deb_upd[i] && sync[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]  <= '0;
        deb_cnt[i] <= '0;
      end
      deb  <= '0;
      pend <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (sync[i] == deb[i] || deb_upd[i]) deb_cnt[i] <= '0;
        else                                 deb_cnt[i] <= deb_cnt[i] + CNT_WIDTH'(1);
        if (deb_upd[i]) deb[i] <= sync[i];
        pend[i] <= deb_rise[i] | (pend[i] & ~clr[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
      cd_cnt  <= '0;
      last_ew <= 1'b1;
      emg_ns  <= 1'b0;
      emg_ew  <= 1'b0;
      busy    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_next;
      tmo_cnt <= (state == S_REQ_NS || state == S_REQ_EW) ? tmo_cnt + CNT_WIDTH'(1) : '0;
      cd_cnt  <= (state == S_COOLDOWN) ? cd_cnt + CNT_WIDTH'(1) : '0;
      if (clr != 2'b00) last_ew <= clr[1];
      emg_ns  <= emg_ns_d;
      emg_ew  <= emg_ew_d;
      busy    <= busy_d;
      fault   <= fault | tmo_evt;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (pend[0] && (!pend[1] || last_ew)) state_next = S_REQ_NS;
        else if (pend[1])                     state_next = S_REQ_EW;
      end
      S_REQ_NS: begin
        if (state_debug == CODE_NS) state_next = S_WAIT_NS;
        else if (tmo_cnt >= TMO_LAST) state_next = S_COOLDOWN;
      end
      S_REQ_EW: begin
        if (state_debug == CODE_EW) state_next = S_WAIT_EW;
        else if (tmo_cnt >= TMO_LAST) state_next = S_COOLDOWN;
      end
      S_WAIT_NS:  if (state_debug != CODE_NS) state_next = S_COOLDOWN;
      S_WAIT_EW:  if (state_debug != CODE_EW) state_next = S_COOLDOWN;
      S_COOLDOWN: if (cd_cnt >= CD_LAST) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Leaving a REQ state is either an acknowledge or a timeout; both release that channel.
  always_comb begin
    emg_ns_d = (state_next == S_REQ_NS);
    emg_ew_d = (state_next == S_REQ_EW);
    busy_d   = (state_next != S_IDLE);
    clr[0]   = (state == S_REQ_NS) && (state_next != S_REQ_NS);
    clr[1]   = (state == S_REQ_EW) && (state_next != S_REQ_EW);
    tmo_evt  = (state == S_REQ_NS || state == S_REQ_EW) && (state_next == S_COOLDOWN);
  end

endmodule

// File: tb/tb_emergency_request_conditioner.sv
// tb/tb_emergency_request_conditioner.sv - directed self-checking bench for emergency_request_conditioner
module tb_emergency_request_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       raw_emg_ns = 1'b0;
  logic       raw_emg_ew = 1'b0;
  logic [2:0] state_debug = 3'd0;
  logic       emg_ns, emg_ew, pending_ns, pending_ew, busy, fault;

  int checks = 0;
  int failures = 0;

  emergency_request_conditioner #(
    .SYNC_STAGES(2),
    .CNT_WIDTH(32),
    .DEBOUNCE_TICKS(4),
    .REQ_TIMEOUT_TICKS(16),
    .COOLDOWN_TICKS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_emg_ns(raw_emg_ns),
    .raw_emg_ew(raw_emg_ew),
    .state_debug(state_debug),
    .emg_ns(emg_ns),
    .emg_ew(emg_ew),
    .pending_ns(pending_ns),
    .pending_ew(pending_ew),
    .busy(busy),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("exclusive", {31'd0, emg_ns & emg_ew}, 32'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_emg_ns"}, emg_ns, 0);
    chk({tag, "_emg_ew"}, emg_ew, 0);
    chk({tag, "_pend_ns"}, pending_ns, 0);
    chk({tag, "_pend_ew"}, pending_ew, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fault"}, fault, 0);
  endtask

  task automatic reset_mid(input string tag);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all_zero(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Power-up reset asserted mid-cycle, before the first edge
    #2 rst = 1'b1;
    #1 chk_all_zero("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Glitch: 3-cycle NS pulse must not produce a request
    raw_emg_ns = 1'b1;
    steps(3);
    raw_emg_ns = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("glitch_pend_ns", pending_ns, 0);
      chk("glitch_emg_ns", emg_ns, 0);
    end

    // Basic service, edge 0 is the first edge sampling raw high
    reset_mid("rst_basic");
    raw_emg_ns = 1'b1;
    steps(5);
    chk("basic_pend_e4", pending_ns, 0);
    step();
    chk("basic_pend_e5", pending_ns, 1);
    chk("basic_emg_e5", emg_ns, 0);
    step();
    chk("basic_emg_e6", emg_ns, 1);
    chk("basic_busy_e6", busy, 1);
    steps(4);
    chk("basic_emg_e10", emg_ns, 1);
    state_debug = 3'd6;
    step();
    chk("basic_emg_e11", emg_ns, 0);
    chk("basic_pend_e11", pending_ns, 0);
    chk("basic_busy_e11", busy, 1);
    steps(9);
    state_debug = 3'd2;
    step();
    steps(7);
    chk("basic_busy_e28", busy, 1);
    step();
    chk("basic_busy_e29", busy, 0);
    steps(10);
    chk("basic_held_emg", emg_ns, 0);
    chk("basic_held_pend", pending_ns, 0);
    chk("basic_held_busy", busy, 0);
    raw_emg_ns = 1'b0;
    state_debug = 3'd0;

    // Simultaneous presses: NS first, EW after cooldown
    reset_mid("rst_sim");
    raw_emg_ns = 1'b1;
    raw_emg_ew = 1'b1;
    steps(6);
    chk("sim_pend_ns_e5", pending_ns, 1);
    chk("sim_pend_ew_e5", pending_ew, 1);
    step();
    chk("sim_emg_ns_e6", emg_ns, 1);
    chk("sim_emg_ew_e6", emg_ew, 0);
    state_debug = 3'd6;
    step();
    chk("sim_emg_ns_e7", emg_ns, 0);
    chk("sim_pend_ns_e7", pending_ns, 0);
    chk("sim_pend_ew_e7", pending_ew, 1);
    state_debug = 3'd0;
    steps(8);
    chk("sim_busy_e15", busy, 1);
    chk("sim_emg_ew_e15", emg_ew, 0);
    step();
    chk("sim_busy_e16", busy, 0);
    chk("sim_emg_ew_e16", emg_ew, 0);
    step();
    chk("sim_emg_ew_e17", emg_ew, 1);
    chk("sim_emg_ns_e17", emg_ns, 0);
    state_debug = 3'd7;
    step();
    chk("sim_emg_ew_e18", emg_ew, 0);
    chk("sim_pend_ew_e18", pending_ew, 0);
    state_debug = 3'd0;
    raw_emg_ns = 1'b0;
    raw_emg_ew = 1'b0;

    // Timeout on EW, then an NS press during the following cooldown
    reset_mid("rst_tmo");
    raw_emg_ew = 1'b1;
    steps(6);
    chk("tmo_pend_e5", pending_ew, 1);
    step();
    chk("tmo_emg_e6", emg_ew, 1);
    for (int i = 7; i <= 21; i++) begin
      step();
      chk("tmo_emg_high", emg_ew, 1);
    end
    chk("tmo_fault_e21", fault, 0);
    step();
    chk("tmo_emg_e22", emg_ew, 0);
    chk("tmo_fault_e22", fault, 1);
    chk("tmo_pend_e22", pending_ew, 0);
    chk("tmo_busy_e22", busy, 1);
    raw_emg_ns = 1'b1;
    steps(5);
    chk("cd_pend_e27", pending_ns, 0);
    step();
    chk("cd_pend_e28", pending_ns, 1);
    chk("cd_emg_e28", emg_ns, 0);
    chk("cd_busy_e28", busy, 1);
    step();
    chk("cd_emg_e29", emg_ns, 0);
    step();
    chk("cd_busy_e30", busy, 0);
    chk("cd_emg_e30", emg_ns, 0);
    step();
    chk("cd_emg_e31", emg_ns, 1);
    chk("cd_fault_e31", fault, 1);
    chk("cd_pend_ew_e31", pending_ew, 0);
    raw_emg_ns = 1'b0;
    raw_emg_ew = 1'b0;

    // Reset during REQ_EW drops the request at once and clears fault
    reset_mid("rst_clr");
    raw_emg_ew = 1'b1;
    steps(7);
    chk("mid_emg_e6", emg_ew, 1);
    steps(2);
    chk("mid_emg_e8", emg_ew, 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    raw_emg_ew = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    steps(10);
    chk_all_zero("mid_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/emergency_request_conditioner.md
# emergency_request_conditioner

Conditions the raw emergency-vehicle inputs (push-buttons or detector contacts) into the clean `emg_ns`/`emg_ew` request levels consumed by `traffic_controller`. It sits directly upstream of the controller and performs four functions: synchronisation, debounce, sticky request latching, and one-at-a-time arbitration. Each request is held until the controller's `state_debug` shows it being served, then released, so a held button cannot retrigger the emergency phase. A cooldown follows every service.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops per raw input (≥2).
- `CNT_WIDTH`, 32: width of all internal counters.
- `DEBOUNCE_TICKS`, 500000: cycles a synchronised level must be stable before it is accepted (≥1).
- `REQ_TIMEOUT_TICKS`, 200000000: maximum cycles a request is driven without acknowledge.
- `COOLDOWN_TICKS`, 100000000: idle cycles after each service or timeout.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `raw_emg_ns` in 1: asynchronous NS emergency input, active-high.
- `raw_emg_ew` in 1: asynchronous EW emergency input, active-high.
- `state_debug` in 3: controller state. 6 = EMG_NS served, 7 = EMG_EW served.
- `emg_ns` out 1: registered NS request to the controller.
- `emg_ew` out 1: registered EW request to the controller.
- `pending_ns` out 1: NS request latched, not yet served.
- `pending_ew` out 1: EW request latched, not yet served.
- `busy` out 1: FSM not in IDLE.
- `fault` out 1: sticky flag, set on request timeout, cleared only by `rst`.

## Operation
- **Per channel, synchroniser:** a `SYNC_STAGES`-flop chain produces the `sync` signal.
- **Per channel, debounce:**
  - A counter clears whenever `sync == deb`.
  - Otherwise it increments.
  - When the counter reaches `DEBOUNCE_TICKS-1` while `sync != deb`, `deb <= sync` and the counter clears.
- **Per channel, pending latch:** a rising edge of `deb` sets `pending_x`.
  - Cleared on acknowledge or timeout of that channel.
  - If set and clear occur in the same cycle, set wins.
- **FSM states:** IDLE, REQ_NS, REQ_EW, WAIT_NS, WAIT_EW, COOLDOWN.
  - **IDLE:**
    - Only one channel pending: go to that channel's REQ state.
    - Both pending: serve the channel not served last (`last_served` resets to EW, so NS wins first).
  - **REQ_x:**
    - `emg_x = 1`; the timeout counter increments each cycle.
    - If `state_debug` equals x's code: clear `pending_x`, set `last_served = x`, go to WAIT_x.
    - Else if the timeout count reaches `REQ_TIMEOUT_TICKS`: clear `pending_x`, set `fault`, set `last_served = x`, go to COOLDOWN.
  - **WAIT_x:**
    - Outputs low.
    - Stay while `state_debug` equals x's code; go to COOLDOWN when it differs.
  - **COOLDOWN:**
    - Outputs low; count `COOLDOWN_TICKS` cycles, then go to IDLE.
    - New presses still set pending flags and are served after IDLE.
- **Request outputs:** `emg_ns`/`emg_ew` are flops loaded with the next-state decode, so they change on the same edge as the state.
  - They are never high simultaneously.
- **Counters:** compare with `>=` at `CNT_WIDTH` bits; no wrap occurs within any state.
- **Reset (asynchronous):**
  - Sync flops, `deb`, all counters, pending latches, `emg_ns`, `emg_ew`, `busy`, `fault` = 0.
  - State = IDLE.
  - Reset mid-request drops the request immediately.

## Timing
- **Raw-to-request latency:** with FSM in IDLE and raw held high from edge k, `pending_x` rises at edge k+SYNC_STAGES+DEBOUNCE_TICKS−1 and `emg_x` rises one edge later.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_TICKS` cycles (after sync) produces no request.
- **Acknowledge:** `emg_x` falls on the first edge after `state_debug` shows x's code.
- **Cooldown:** COOLDOWN lasts exactly `COOLDOWN_TICKS` cycles.
- **Timeout:** `emg_x` stays high for exactly `REQ_TIMEOUT_TICKS` cycles when no acknowledge arrives.
- **Opposite-channel press:** a press on the other channel during REQ/WAIT/COOLDOWN is latched and issued after COOLDOWN.

## Test plan
Bench parameters: SYNC_STAGES=2, DEBOUNCE_TICKS=4, REQ_TIMEOUT_TICKS=16, COOLDOWN_TICKS=8.
- **Reset and glitch rejection:** assert `rst` mid-cycle → all outputs 0 immediately. A 3-cycle `raw_emg_ns` pulse → no `pending_ns`, `emg_ns` stays 0.
- **Basic service:** hold `raw_emg_ns` from edge 0 → `pending_ns` at edge 5, `emg_ns` at edge 6. Model drives `state_debug`=6 at edge 10 → `emg_ns` 0 at edge 11. `state_debug`=2 at edge 20 → COOLDOWN. `busy` falls 8 cycles later. Held button does not re-request.
- **Simultaneous presses:** both raw inputs rise on the same edge → EW pending latched; NS served first. After cooldown, `emg_ew` asserts. Outputs are never both 1.
- **Timeout:** press EW, `state_debug` never reaches 7 → `emg_ew` high exactly 16 cycles, then 0. `fault` = 1 and stays 1 until `rst`.
- **Press during cooldown:** NS press during COOLDOWN → `pending_ns` set, `emg_ns` asserted the edge after IDLE is entered.
- **Reset mid-request:** `rst` during REQ_EW → `emg_ew` 0 asynchronously. After release, the FSM is in IDLE with no pending.
